// File: rtl/uart_word_loader.sv
// uart_word_loader: parses framed load packets arriving from the UART
// receiver and writes the assembled 16-bit words into instruction memory.
// Packet layout: header, word count N, N x {lo, hi} data bytes, then the
// XOR of all data bytes. The CPU is held while a packet is in flight and
// after a failed load, until the next valid header starts a reload.
module uart_word_loader #(
   parameter int         ADDR_W      = 8,
   parameter int         TIMEOUT_CYC = 65535,
   parameter logic [7:0] HDR_BYTE    = 8'hA5
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              i_rx_valid,
   input  logic [7:0]        i_rx_data,
   input  logic              i_rx_stop,
   output logic              o_mem_we,
   output logic [ADDR_W-1:0] o_mem_addr,
   output logic [15:0]       o_mem_wdata,
   output logic              o_busy,
   output logic              o_load_done,
   output logic              o_load_err,
   output logic              o_cpu_hold
);

   typedef enum logic [2:0] {
      IDLE,
      COUNT,
      LO,
      HI,
      CSUM
   } state_t;

   // Counter wide enough to hold TIMEOUT_CYC; the abort fires on the edge
   // where the idle-cycle count would reach TIMEOUT_CYC-1.
   localparam int              TW       = $clog2(TIMEOUT_CYC + 1);
   localparam logic [TW-1:0]   TMO_LAST = TW'(TIMEOUT_CYC - 2);

   state_t            state_reg;
   logic [7:0]        words_left_reg;
   logic [7:0]        lo_reg;
   logic [7:0]        csum_reg;
   logic [ADDR_W-1:0] addr_reg;
   logic [TW-1:0]     tmo_cnt_reg;

   // Packet parser: one state step per received byte, plus the inter-byte
   // timeout watchdog while a packet is open.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg      <= IDLE;
         words_left_reg <= '0;
         lo_reg         <= '0;
         csum_reg       <= '0;
         addr_reg       <= '0;
         tmo_cnt_reg    <= '0;
         o_mem_we       <= 1'b0;
         o_mem_addr     <= '0;
         o_mem_wdata    <= '0;
         o_load_done    <= 1'b0;
         o_load_err     <= 1'b0;
      end else begin
         // Strobes default low so each lasts exactly one cycle.
         o_mem_we    <= 1'b0;
         o_load_done <= 1'b0;

         if (state_reg == IDLE) begin
            tmo_cnt_reg <= '0;
            // Only a clean header opens a packet; everything else is noise.
            if (i_rx_valid && i_rx_stop && (i_rx_data == HDR_BYTE)) begin
               state_reg  <= COUNT;
               o_load_err <= 1'b0;
               csum_reg   <= '0;
               addr_reg   <= '0;
               o_mem_addr <= '0;
            end
         end else if (i_rx_valid) begin
            // A received byte always wins over a coincident timeout.
            tmo_cnt_reg <= '0;
            if (!i_rx_stop) begin
               // Framing error inside a packet: abort without writing.
               o_load_err <= 1'b1;
               state_reg  <= IDLE;
            end else begin
               case (state_reg)
                  COUNT: begin
                     words_left_reg <= i_rx_data;
                     state_reg      <= (i_rx_data == 8'd0) ? CSUM : LO;
                  end
                  LO: begin
                     lo_reg    <= i_rx_data;
                     csum_reg  <= csum_reg ^ i_rx_data;
                     state_reg <= HI;
                  end
                  HI: begin
                     o_mem_we       <= 1'b1;
                     o_mem_wdata    <= {i_rx_data, lo_reg};
                     o_mem_addr     <= addr_reg;
                     addr_reg       <= addr_reg + 1'b1;
                     csum_reg       <= csum_reg ^ i_rx_data;
                     words_left_reg <= words_left_reg - 8'd1;
                     state_reg      <= (words_left_reg == 8'd1) ? CSUM : LO;
                  end
                  CSUM: begin
                     if (i_rx_data == csum_reg) begin
                        o_load_done <= 1'b1;
                     end else begin
                        o_load_err <= 1'b1;
                     end
                     state_reg <= IDLE;
                  end
                  default: begin
                     state_reg <= IDLE;
                  end
               endcase
            end
         end else if (tmo_cnt_reg == TMO_LAST) begin
            // Sender went quiet mid-packet: give up and flag the load bad.
            tmo_cnt_reg <= '0;
            o_load_err  <= 1'b1;
            state_reg   <= IDLE;
         end else begin
            tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
         end
      end
   end

   // Status outputs derive directly from registered state.
   assign o_busy     = (state_reg != IDLE);
   assign o_cpu_hold = o_busy | o_load_err;

endmodule

// File: doc/uart_word_loader.md
Name: uart_word_loader

Overview:
Downstream consumer of the UART receiver. Takes received bytes (done pulse, data, stop bit) and parses a framed load packet: header 0xA5, word count, 2N data bytes (low byte first), then an XOR checksum. It writes assembled 16-bit words into the CPU instruction memory from address 0 upward. It holds the CPU in reset/stall while loading and when the last load failed.

Parameters:
ADDR_W, 8, instruction memory address width (word addressed; N ≤ 255 never wraps)
TIMEOUT_CYC, 65535, clk cycles allowed between accepted bytes inside a packet before abort
HDR_BYTE, 8'hA5, packet header value

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
i_rx_valid  input  1  one-cycle pulse: byte received (receiver done strobe)
i_rx_data  input  8  received byte, valid with i_rx_valid
i_rx_stop  input  1  sampled stop bit of that byte; 0 = framing error
o_mem_we  output  1  instruction memory write enable, one-cycle pulse
o_mem_addr  output  ADDR_W  write address
o_mem_wdata  output  16  write data {hi, lo}
o_busy  output  1  packet in progress (state != IDLE)
o_load_done  output  1  one-cycle pulse: packet accepted, checksum good
o_load_err  output  1  sticky error flag
o_cpu_hold  output  1  o_busy | o_load_err

Behaviour:
- Reset (async, active-high): state=IDLE; o_mem_we=0, o_mem_addr=0, o_mem_wdata=0, o_load_done=0, o_load_err=0, o_busy=0, o_cpu_hold=0; internal count, lo-byte, checksum and timeout counter cleared. Reset mid-packet abandons it; words already written stay in memory.
- A byte is "accepted" on any cycle with i_rx_valid=1. All state updates happen on that clk edge.
- States:
  - IDLE:
    - Accepted byte == HDR_BYTE with i_rx_stop=1 -> COUNT; clear o_load_err, checksum=0, addr=0.
    - Other bytes, and bytes with framing errors, are ignored.
  - COUNT: byte -> words_left = byte. If 0 -> CSUM, else -> LO.
  - LO: latch lo = byte; checksum ^= byte; -> HI.
  - HI:
    - Next cycle: o_mem_we=1, o_mem_wdata={byte, lo}, o_mem_addr = current addr.
    - addr increments after the write (addr visible on o_mem_addr, held until the next write).
    - checksum ^= byte; words_left -= 1; if it becomes 0 -> CSUM, else -> LO.
  - CSUM:
    - Byte == checksum -> o_load_done=1 for exactly one cycle (cycle after acceptance); -> IDLE.
    - Mismatch -> o_load_err=1; -> IDLE.
- Header/count bytes are not included in the checksum.
- Framing error: accepted byte with i_rx_stop=0 in COUNT/LO/HI/CSUM -> o_load_err=1, -> IDLE, no memory write for that byte.
- Timeout:
  - Counter clears on every accepted byte and in IDLE; increments each clk otherwise.
  - Reaching TIMEOUT_CYC-1 -> o_load_err=1, -> IDLE.
  - If a byte is accepted in the same cycle the counter hits the limit, the byte wins (processed, counter cleared, no error).
- o_load_err stays set until the next valid header is accepted; o_cpu_hold therefore stalls the CPU after a failed load until a reload starts (and remains high through it).
- o_mem_we is never asserted in IDLE, and never more than once per HI byte; o_load_done and o_mem_we never coincide.
- i_rx_valid assumed to be a single-cycle pulse; back-to-back pulses on consecutive cycles are each processed.

Test Plan:
- Good load: bytes A5,02,34,12,78,56,08 (stop=1) -> o_mem_we pulses with addr0/0x1234 then addr1/0x5678; o_load_done pulse one cycle after byte 08; o_busy/o_cpu_hold high from header to done, then 0; o_load_err=0.
- Bad checksum: A5,01,CD,AB,00 -> one write addr0=0xABCD; no o_load_done; o_load_err=1, o_cpu_hold=1 in IDLE. Follow with A5 -> o_load_err clears.
- Zero count and noise: bytes 11,22 then A5,00,00 -> 11/22 ignored (o_busy stays 0); no writes; o_load_done pulse.
- Framing error: A5,02,34 then 12 with stop=0 -> no write, o_load_err=1, IDLE. Next A5 with stop=0 in IDLE is ignored (err stays 1).
- Timeout (TIMEOUT_CYC=16): A5,01,44 then silence -> o_load_err=1 exactly 15 cycles after byte 44. Repeat with a byte arriving on the limit cycle -> processed, no error.
- Reset mid-packet: assert reset after A5,02,34,12 -> all outputs 0 immediately (async), state IDLE; word 0x1234 already written and not rewritten.
